// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory host/pipeline arbiter.
// Latency: n/a. Backpressure: n/a.
// Holds the FSM state encoding and the default starvation limit.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        ACC  = 2'd2,
        RESP = 2'd3
    } arbState_t;

    localparam int STARVE_LIMIT_DEFAULT = 8;
    localparam int STARVE_CNT_W         = 8;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of ARB cycles in which the pipeline kept the host out.
// Latency: atLimit is combinational from the registered count.
// Backpressure: none; clear has priority over increment.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic atLimit
);

    logic [STARVE_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign atLimit = (cnt == STARVE_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the pipeline MEM stage and a host port.
// Latency: host_req->host_gnt 2 cycles, ->host_rvalid 3 cycles when the pipe is idle.
// Backpressure: pipe_stall only in the host access cycle; DMEM_ARB_STARVE_GUARD_EN bounds host wait.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_re,
    input  logic              pipe_we,
    input  logic [DATA_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_busy,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if ((STARVE_LIMIT < 2) || (STARVE_LIMIT > ((1 << STARVE_CNT_W) - 1))) begin : gBadLimit
        $error("dmem_arbiter: STARVE_LIMIT out of range");
    end

    arbState_t         state;
    logic              capWe;
    logic [DATA_W-1:0] capAddr;
    logic [DATA_W-1:0] capWdata;
    logic              pipeBusy;
    logic              arbGo;

    assign pipeBusy = pipe_re | pipe_we;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic starveHit;

    dmem_arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) uStarveCnt (
        .clk    (clk),
        .reset  (reset),
        .clr    ((state != ARB) || arbGo),
        .inc    ((state == ARB) && pipeBusy),
        .atLimit(starveHit)
    );

    // The last permitted ARB cycle takes the port even if the pipe is still busy.
    assign arbGo = !pipeBusy || starveHit;
`else
    assign arbGo = !pipeBusy;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            capWe       <= 1'b0;
            capAddr     <= '0;
            capWdata    <= '0;
            host_rdata  <= '0;
            host_busy   <= 1'b0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_req) begin
                        state     <= ARB;
                        host_busy <= 1'b1;
                        capWe     <= host_we;
                        capAddr   <= host_addr;
                        capWdata  <= host_wdata;
                    end
                end
                ARB: begin
                    if (arbGo) begin
                        state    <= ACC;
                        host_gnt <= 1'b1;
                    end
                end
                ACC: begin
                    host_gnt <= 1'b0;
                    if (capWe) begin
                        state     <= IDLE;
                        host_busy <= 1'b0;
                    end else begin
                        state       <= RESP;
                        host_rdata  <= mem_rdata;
                        host_rvalid <= 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    host_rvalid <= 1'b0;
                    host_busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The memory port belongs to the pipeline except during the single ACC cycle.
    always_comb begin
        mem_re     = pipe_re;
        mem_we     = pipe_we;
        mem_addr   = pipe_addr;
        mem_wdata  = pipe_wdata;
        pipe_stall = 1'b0;
        if (state == ACC) begin
            mem_re     = !capWe;
            mem_we     = capWe;
            mem_addr   = capAddr;
            mem_wdata  = capWdata;
            pipe_stall = pipeBusy;
        end
    end

    assign pipe_rdata = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, 32: data and address width.
REQ-002 Parameter STARVE_LIMIT, 8: maximum blocked ARB cycles before the host access is forced (range 2..255).
REQ-003 Port clk  in  1: single clock, all state on rising edge.
REQ-004 Port reset  in  1: asynchronous, active-high reset.
REQ-005 Ports pipe_re, pipe_we  in  1 each: pipeline MEM-stage read/write request.
REQ-006 Ports pipe_addr, pipe_wdata  in  DATA_W each: pipeline address/write data.
REQ-007 Port pipe_rdata  out  DATA_W: equals mem_rdata combinationally.
REQ-008 Port pipe_stall  out  1: pipeline MEM access blocked this cycle.
REQ-009 Ports host_req, host_we  in  1 each: host access request; host_we=1 means write.
REQ-010 Ports host_addr, host_wdata  in  DATA_W each: host address/write data.
REQ-011 Ports host_busy, host_gnt, host_rvalid  out  1 each: request pending, access cycle, read data valid.
REQ-012 Port host_rdata  out  DATA_W: registered host read data.
REQ-013 Ports mem_re, mem_we  out  1 each; mem_addr, mem_wdata  out  DATA_W each; mem_rdata  in  DATA_W: single-port data memory (combinational read, write on clock edge).

Function
REQ-014 FSM states IDLE, ARB, ACC, RESP; host_busy=1 in every state except IDLE.
REQ-015 IDLE: host_req=1 -> ARB, capturing host_we/host_addr/host_wdata into internal registers; host_req ignored in all other states.
REQ-016 ARB: pipe_re=0 and pipe_we=0 -> ACC; else starvation counter increments.
REQ-017 ACC: mem port driven from captured host registers, host_gnt=1 for exactly one cycle; write commits on the closing edge.
REQ-018 ACC read: mem_rdata latched into host_rdata at the closing edge -> RESP; ACC write -> IDLE.
REQ-019 RESP: host_rvalid=1 for exactly one cycle; host_rdata held until the next read completes; -> IDLE.
REQ-020 In every state except ACC, mem_* mirrors pipe_*; pipe_stall=0.
REQ-021 In ACC, pipe_stall = pipe_re | pipe_we.
REQ-022 Uncontended latency: host_req to host_gnt = 2 cycles; host_req to host_rvalid = 3 cycles.
REQ-023 Starvation counter clears on every ARB exit; it never wraps.

Reset
REQ-024 Reset forces IDLE, counter=0, host_rdata=0, captured registers=0, and host_busy/host_gnt/host_rvalid/pipe_stall=0 immediately.
REQ-025 Reset before the ACC closing edge drops the pending host access with no memory write.

Configuration
REQ-026 DMEM_ARB_STARVE_GUARD_EN defined: in ARB, when the counter equals STARVE_LIMIT-1 and the pipe is busy, go to ACC (forced); ARB lasts at most STARVE_LIMIT cycles.
REQ-027 DMEM_ARB_STARVE_GUARD_EN undefined: counter logic absent; pipeline has strict priority, and the host waits in ARB indefinitely.

Structure
REQ-028 Package dmem_arb_pkg holds the state enum (2 bits) and the default STARVE_LIMIT constant.
REQ-029 Sub-module dmem_arb_starve_cnt (saturating counter with clear/increment/at-limit) is instantiated only under DMEM_ARB_STARVE_GUARD_EN.

Verification
REQ-030 Uncontended host read:
- stimulus: pipe idle; host_req pulse, addr 0x10, mem[0x10]=0xDEADBEEF.
- response: host_gnt at +2; host_rvalid at +3 with host_rdata 0xDEADBEEF.
REQ-031 Host write colliding with the pipeline:
- stimulus: host write 0x20 <- 0x5A5A5A5A; pipe_re rises in the ACC cycle.
- response: pipe_stall=1 exactly that cycle; mem[0x20]=0x5A5A5A5A.
REQ-032 Starvation guard:
- stimulus: guard enabled, STARVE_LIMIT=8; pipe_we held high; host_req.
- response: ARB lasts 8 cycles; forced ACC with pipe_stall=1; pipe sees no further stall.
REQ-033 Guard disabled:
- stimulus: same stimulus as REQ-032 for 100 cycles.
- response: host_gnt never asserts; pipe_stall stays 0; ACC follows within 1 cycle of pipe going idle.
REQ-034 Reset mid-operation:
- stimulus: reset asserted in ARB with a pending host write of 0x77 to 0x30.
- response: outputs 0 immediately; mem[0x30] unchanged; next host_req is served normally.
REQ-035 Back-to-back requests:
- stimulus: host_req held high across two reads.
- response: second capture occurs in the IDLE cycle after RESP; gap between the two host_rvalid pulses = 4 cycles.
